// File: rtl/filtered_angle_calc.sv
// Block-averages (x,y) samples, then folds to the first quadrant and runs a
// vectoring CORDIC to produce theta in 0..pi/2 plus the original quadrant.
module filtered_angle_calc #(
    parameter int IN_W     = 16,
    parameter int ANG_W    = 17,
    parameter int ITER     = 14,
    parameter int AVG_LOG2 = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  cx_in,
    input  logic signed [IN_W-1:0]  cy_in,
    input  logic                    clr,
    output logic signed [ANG_W-1:0] theta_1st_quad,
    output logic [1:0]              quadrant,
    output logic                    out_valid,
    output logic                    busy
);

    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int BLK   = 1 << AVG_LOG2;
    localparam int DW    = IN_W + 2;
    localparam int ZW    = ANG_W + 1;
    localparam int SHW   = $clog2(IN_W);

    localparam logic signed [IN_W-1:0] IN_MIN = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [ZW-1:0]   QMAX   = {2'b00, 1'b1, {(ANG_W-2){1'b0}}};

    // atan(2^-i), pi/2 = 2^30, rounded to nearest
    localparam logic [31:0] ATAN_TBL [16] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
    };

    typedef struct packed {
        logic signed [IN_W-1:0] x;
        logic signed [IN_W-1:0] y;
    } sample_t;

    typedef enum logic [1:0] {IDLE, FOLD, ROT, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc_x, acc_y, sum_x, sum_y;
    logic [CW-1:0]           cnt;
    sample_t                 pend_s, work_s;
    logic                    pend, last, accept, blk_done, consume;

    assign last      = (cnt == CW'(BLK - 1));
    assign in_ready  = !(pend && last);
    assign accept    = in_valid && in_ready;
    assign blk_done  = accept && !clr && last;
    assign consume   = (state == IDLE) && pend;
    assign sum_x     = acc_x + ACC_W'(cx_in);
    assign sum_y     = acc_y + ACC_W'(cy_in);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (clr || (accept && last)) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
        end else if (accept) begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= cnt + 1'b1;
        end
    end

    // A block finishing while IDLE takes the old pend keeps pend set with the new average
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            pend_s <= '0;
        end else if (blk_done) begin
            pend   <= 1'b1;
            pend_s <= {IN_W'(sum_x >>> AVG_LOG2), IN_W'(sum_y >>> AVG_LOG2)};
        end else if (consume) begin
            pend   <= 1'b0;
        end
    end

    logic signed [DW-1:0] xr, yr, x_nxt, y_nxt, dx, dy;
    logic signed [ZW-1:0] zr, z_nxt, at;
    logic [4:0]           iter;
    logic [1:0]           quad_w, fold_q;
    logic                 zero_w;
    logic [IN_W-2:0]      ax, ay, mag, nrm_x, nrm_y;
    logic [SHW-1:0]       sh;
    logic [ANG_W-1:0]     th_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend) state_nxt = FOLD;
            FOLD:    state_nxt = ROT;
            ROT:     if (iter == 5'(ITER - 1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Fold to magnitudes, then normalise both by the same left shift so small
    // inputs use the full datapath precision; the angle is unchanged.
    always_comb begin
        fold_q = {work_s.y[IN_W-1], work_s.x[IN_W-1] ^ work_s.y[IN_W-1]};
        if (!work_s.x[IN_W-1])       ax = work_s.x[IN_W-2:0];
        else if (work_s.x == IN_MIN) ax = '1;
        else                         ax = (IN_W-1)'(-work_s.x);
        if (!work_s.y[IN_W-1])       ay = work_s.y[IN_W-2:0];
        else if (work_s.y == IN_MIN) ay = '1;
        else                         ay = (IN_W-1)'(-work_s.y);
        mag = ax | ay;
        sh  = '0;
        for (int k = 0; k < IN_W-1; k++)
            if (mag[k]) sh = SHW'(IN_W - 2 - k);
        nrm_x = ax << sh;
        nrm_y = ay << sh;
    end

    always_comb begin
        dx = xr >>> iter;
        dy = yr >>> iter;
        at = $signed(ZW'(ATAN_TBL[iter[3:0]] >> (32 - ANG_W)));
        if (!yr[DW-1]) begin
            x_nxt = xr + dy;
            y_nxt = yr - dx;
            z_nxt = zr + at;
        end else begin
            x_nxt = xr - dy;
            y_nxt = yr + dx;
            z_nxt = zr - at;
        end
        if (zero_w || z_nxt[ZW-1]) th_nxt = '0;
        else if (z_nxt > QMAX)     th_nxt = QMAX[ANG_W-1:0];
        else                       th_nxt = z_nxt[ANG_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_s         <= '0;
            xr             <= '0;
            yr             <= '0;
            zr             <= '0;
            iter           <= '0;
            quad_w         <= '0;
            zero_w         <= 1'b0;
            theta_1st_quad <= '0;
            quadrant       <= '0;
        end else begin
            case (state)
                IDLE: if (pend) work_s <= pend_s;
                FOLD: begin
                    xr     <= {3'b000, nrm_x};
                    yr     <= {3'b000, nrm_y};
                    zr     <= '0;
                    iter   <= '0;
                    quad_w <= fold_q;
                    zero_w <= (mag == '0);
                end
                ROT: begin
                    xr   <= x_nxt;
                    yr   <= y_nxt;
                    zr   <= z_nxt;
                    iter <= iter + 1'b1;
                    if (iter == 5'(ITER - 1)) begin
                        theta_1st_quad <= th_nxt;
                        quadrant       <= quad_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_filtered_angle_calc.sv
// Bench for filtered_angle_calc: direct vectors, averaging sequences, reset abort
// and random streams scored against an atan2 reference.
module tb_filtered_angle_calc;
    localparam int ITER = 14;
    localparam int TOL  = ITER / 2 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               iv0 = 1'b0, clr0 = 1'b0, ir0, ov0, bz0;
    logic signed [15:0] x0 = '0, y0 = '0;
    logic signed [16:0] th0;
    logic [1:0]         qd0;
    logic               iv2 = 1'b0, clr2 = 1'b0, ir2, ov2, bz2;
    logic signed [15:0] x2 = '0, y2 = '0;
    logic signed [16:0] th2;
    logic [1:0]         qd2;

    filtered_angle_calc #(.IN_W(16), .ANG_W(17), .ITER(ITER), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .cx_in(x0), .cy_in(y0),
        .clr(clr0), .theta_1st_quad(th0), .quadrant(qd0), .out_valid(ov0), .busy(bz0));

    filtered_angle_calc #(.IN_W(16), .ANG_W(17), .ITER(ITER), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .cx_in(x2), .cy_in(y2),
        .clr(clr2), .theta_1st_quad(th2), .quadrant(qd2), .out_valid(ov2), .busy(bz2));

    typedef struct { int x; int y; } smp_t;
    typedef struct { int x; int y; int th; int qd; } vec_t;

    int   n_pass = 0, n_chk = 0, cyc = 0, acc_cyc0 = 0;
    int   acc0 = 0, res0 = 0, res2 = 0, th2_last = 0, qd2_last = 0;
    bit   stall0 = 1'b0;
    smp_t sbq[$];

    function automatic int mag_sat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    function automatic real ref_theta(input int x, input int y);
        int ax, ay;
        ax = mag_sat(x);
        ay = mag_sat(y);
        if (ax == 0 && ay == 0) return 0.0;
        return $atan2(real'(ay), real'(ax)) * 32768.0 / (3.141592653589793 / 2.0);
    endfunction

    function automatic int ref_quad(input int x, input int y);
        if (x >= 0 && y >= 0) return 0;
        if (x < 0 && y >= 0)  return 1;
        if (x < 0 && y < 0)   return 2;
        return 3;
    endfunction

    task automatic chk(input string nm, input bit ok, input int got, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic chk_th(input string nm, input int got, input real exp);
        real d;
        d = real'(got) - exp;
        n_chk++;
        if (d <= real'(TOL) && d >= -real'(TOL)) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, got, int'(exp), TOL);
    endtask

    // Accepted-sample capture and reset flush, sampled before the edge updates state
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) sbq.delete();
        else if (iv0 && ir0 && !clr0) begin
            sbq.push_back('{int'(x0), int'(y0)});
            acc0++;
        end
        if (!rst && iv0 && !ir0) stall0 = 1'b1;
    end

    initial begin : mon_res
        smp_t s;
        forever begin
            @(negedge clk);
            if (ov0) begin
                res0++;
                if (sbq.size() == 0) chk("sb_unexpected_strobe", 1'b0, 1, 0);
                else begin
                    s = sbq.pop_front();
                    chk_th("sb_theta", int'(th0), ref_theta(s.x, s.y));
                    chk("sb_quad", int'(qd0) == ref_quad(s.x, s.y), int'(qd0), ref_quad(s.x, s.y));
                end
            end
            if (ov2) begin
                res2++;
                th2_last = int'(th2);
                qd2_last = int'(qd2);
            end
        end
    end

    task automatic send0(input int x, input int y, output bit ok);
        @(negedge clk);
        x0 = 16'(x); y0 = 16'(y); iv0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ir0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc0 = cyc;
        iv0 = 1'b0;
    endtask

    task automatic wait_res0(output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 60; i++) begin
            if (ov0) begin ok = 1'b1; lat = cyc - acc_cyc0 + 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic send2(input int x, input int y, input bit c);
        @(negedge clk);
        x2 = 16'(x); y2 = 16'(y); iv2 = 1'b1; clr2 = c;
        for (int i = 0; i < 100 && !ir2; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic wait_res2(input int target);
        for (int i = 0; i < 60 && res2 < target; i++) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        bit   ok, okr;
        int   lat, n, a, r, sx, sy, ax, ay, rx, ry;
        tbl[0] = '{1000, 1000, 16384, 0};
        tbl[1] = '{-1000, 0, 0, 1};
        tbl[2] = '{0, -500, 32768, 3};
        tbl[3] = '{-32768, -32768, 16384, 2};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{-32768, 0, 0, 1};
        tbl[6] = '{7, -7, 16384, 3};
        tbl[7] = '{0, 300, 32768, 0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", ir0 == 1'b1, ir0, 1);
        chk("rst_out_valid", ov0 == 1'b0, ov0, 0);
        chk("rst_busy", bz0 == 1'b0, bz0, 0);
        chk("rst_theta", th0 == 0, int'(th0), 0);
        chk("rst_quad", qd0 == 0, int'(qd0), 0);
        chk("rst_in_ready2", ir2 == 1'b1, ir2, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            send0(tbl[i].x, tbl[i].y, ok);
            wait_res0(lat, okr);
            chk($sformatf("tbl%0d_latency", i), ok && okr && lat == ITER + 3, lat, ITER + 3);
            chk_th($sformatf("tbl%0d_theta", i), int'(th0), real'(tbl[i].th));
            chk($sformatf("tbl%0d_quad", i), int'(qd0) == tbl[i].qd, int'(qd0), tbl[i].qd);
        end
        repeat (6) @(negedge clk);
        chk_th("hold_theta", int'(th0), real'(tbl[7].th));
        chk("hold_quad", int'(qd0) == tbl[7].qd, int'(qd0), tbl[7].qd);

        // Reset during ROT iteration 5 must drop the computation silently
        send0(1000, 500, ok);
        repeat (7) @(negedge clk);
        chk("mid_rot_busy", bz0 == 1'b1, bz0, 1);
        n = res0;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_busy", bz0 == 1'b0, bz0, 0);
        chk("arst_theta", th0 == 0, int'(th0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_stale_strobe", res0 == n, res0 - n, 0);
        send0(0, 300, ok);
        wait_res0(lat, okr);
        chk("post_rst_result", okr, okr, 1);
        chk_th("post_rst_theta", int'(th0), 32768.0);
        chk("post_rst_quad", qd0 == 0, int'(qd0), 0);
        @(negedge clk);

        // in_valid held high: back-pressure, one result per accepted sample
        a = acc0; r = res0; stall0 = 1'b0;
        iv0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x0 = 16'($urandom); y0 = 16'($urandom);
            @(negedge clk);
        end
        iv0 = 1'b0;
        for (int i = 0; i < 200 && (sbq.size() != 0 || bz0); i++) @(negedge clk);
        chk("stream_drained", sbq.size() == 0, sbq.size(), 0);
        chk("stream_balance", acc0 - a == res0 - r, res0 - r, acc0 - a);
        chk("stream_accepts", acc0 - a == 4, acc0 - a, 4);
        chk("stream_stall_seen", stall0, stall0, 1);

        a = acc0; r = res0;
        for (int i = 0; i < 20; i++) begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 5) == 0) rx = -32768;
            if ($urandom_range(0, 5) == 0) ry = 0;
            send0(rx, ry, ok);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        for (int i = 0; i < 200 && (sbq.size() != 0 || bz0); i++) @(negedge clk);
        chk("gap_balance", acc0 - a == res0 - r && sbq.size() == 0, res0 - r, acc0 - a);

        // Averaging block of four
        n = res2;
        send2(100, 0, 1'b0); send2(100, 0, 1'b0); send2(100, 400, 1'b0);
        repeat (5) @(negedge clk);
        chk("avg_no_early", res2 == n, res2 - n, 0);
        send2(100, 400, 1'b0);
        repeat (40) @(negedge clk);
        chk("avg_count", res2 == n + 1, res2 - n, 1);
        chk_th("avg_theta", th2_last, ref_theta(100, 200));
        chk("avg_quad", qd2_last == 0, qd2_last, 0);

        // clr flushes a partial block
        n = res2;
        send2(-20000, 9000, 1'b0); send2(-20000, 9000, 1'b0);
        @(negedge clk); clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0;
        for (int i = 0; i < 4; i++) send2(50, 50, 1'b0);
        repeat (40) @(negedge clk);
        chk("clr_count", res2 == n + 1, res2 - n, 1);
        chk_th("clr_theta", th2_last, 16384.0);

        // clr with an accepted sample discards that sample
        n = res2;
        send2(20000, -3000, 1'b1);
        for (int i = 0; i < 3; i++) send2(0, 100, 1'b0);
        repeat (5) @(negedge clk);
        chk("clr_drop_no_early", res2 == n, res2 - n, 0);
        send2(0, 100, 1'b0);
        repeat (40) @(negedge clk);
        chk("clr_drop_count", res2 == n + 1, res2 - n, 1);
        chk_th("clr_drop_theta", th2_last, 32768.0);

        for (int b = 0; b < 4; b++) begin
            sx = 0; sy = 0; n = res2;
            for (int k = 0; k < 4; k++) begin
                rx = int'($urandom_range(0, 65535)) - 32768;
                ry = int'($urandom_range(0, 65535)) - 32768;
                sx += rx; sy += ry;
                send2(rx, ry, 1'b0);
            end
            ax = int'($floor(real'(sx) / 4.0));
            ay = int'($floor(real'(sy) / 4.0));
            wait_res2(n + 1);
            chk($sformatf("rand_avg%0d_count", b), res2 == n + 1, res2 - n, 1);
            chk_th($sformatf("rand_avg%0d_theta", b), th2_last, ref_theta(ax, ay));
            chk($sformatf("rand_avg%0d_quad", b), qd2_last == ref_quad(ax, ay), qd2_last, ref_quad(ax, ay));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/filtered_angle_calc.md
FILTERED_ANGLE_CALC -- requirements
Module: filtered_angle_calc

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  IN_W, 16, signed input sample width.
  ANG_W, 17, signed angle output width.
  ITER, 14, CORDIC iterations (legal range 8..16).
  AVG_LOG2, 0, averaging block = 2^AVG_LOG2 samples (legal range 0..4).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning; clock and reset first:
  clk  in  1  clock.
  rst  in  1  reset, asynchronous, active-high.
  in_valid  in  1  sample present.
  in_ready  out  1  sample accepted when in_valid & in_ready.
  cx_in  in  IN_W  signed X.
  cy_in  in  IN_W  signed Y.
  clr  in  1  synchronous flush of the partial average.
  theta_1st_quad  out  ANG_W  signed first-quadrant angle.
  quadrant  out  2  quadrant code.
  out_valid  out  1  one-cycle result strobe.
  busy  out  1  CORDIC engine not IDLE.

Function
REQ-003 Accumulator SHALL sum 2^AVG_LOG2 accepted samples per channel at width IN_W+AVG_LOG2, with no overflow possible.
REQ-004 On the last sample of a block, the average (sum arithmetic-shifted right by AVG_LOG2, i.e. floor) SHALL be written to a pending register with pend=1, and the accumulator SHALL clear in the same cycle.
REQ-005 in_ready SHALL be 0 only when pend=1 and the next accepted sample would complete a block; otherwise in_ready SHALL be 1.
REQ-006 clr SHALL zero the accumulator and sample count; it SHALL NOT affect pend or a running CORDIC; clr together with an accepted sample SHALL discard that sample.
REQ-007 FSM states SHALL be IDLE, FOLD, ROT, DONE.
  IDLE->FOLD when pend=1; pend clears in the same cycle.
  FOLD->ROT after 1 cycle.
  ROT->DONE after exactly ITER cycles.
  DONE->IDLE after 1 cycle, with out_valid=1 in DONE.
REQ-008 If a block completes in the same cycle that IDLE consumes pend, pend SHALL remain 1 with the new data and no sample SHALL be lost.
REQ-009 FOLD SHALL set quadrant = 0 (x>=0,y>=0), 1 (x<0,y>=0), 2 (x<0,y<0), 3 (x>=0,y<0), and SHALL load |x|,|y|, with the most-negative value saturating to 2^(IN_W-1)-1.
REQ-010 ROT SHALL perform vectoring CORDIC, one iteration per cycle, on x/y datapaths of width IN_W+2, with z accumulating atan(2^-i).
REQ-011 atan(2^-i) constants SHALL be a 16-entry table scaled pi/2 = 2^30, rounded to nearest, then arithmetic-shifted to the ANG_W scale pi/2 = 2^(ANG_W-2).
REQ-012 theta_1st_quad SHALL equal atan2(|y|,|x|) in the range 0..2^(ANG_W-2), with error <= ITER/2+2 LSB.
REQ-013 Input (0,0) SHALL give theta 0 and quadrant 0.
REQ-014 theta_1st_quad and quadrant SHALL hold their last result until the next DONE.
REQ-015 Latency SHALL be ITER+3 cycles from the accepting edge of the block's last sample to the out_valid cycle, when the FSM is idle.
REQ-016 Maximum throughput SHALL be one result per ITER+3 cycles.
REQ-017 busy SHALL be 1 in FOLD, ROT and DONE.

Reset
REQ-018 rst SHALL asynchronously force: FSM to IDLE; pend, accumulator and count to 0; theta_1st_quad=0, quadrant=0, out_valid=0, busy=0, in_ready=1.
REQ-019 Reset mid-ROT SHALL abort the computation with no out_valid; the first post-reset result SHALL come only from post-reset samples.

Verification
REQ-020 AVG_LOG2=0, sample (1000,1000) -> out_valid 17 cycles later, theta 16384±9, quadrant 0.
REQ-021 Samples (-1000,0), (0,-500), (-32768,-32768) -> results in order: (theta 0±9, quadrant 1); (theta 32768±9, quadrant 3); (theta 16384±9, quadrant 2).
REQ-022 AVG_LOG2=2, samples (100,0),(100,0),(100,400),(100,400) -> exactly one result, average (100,200), theta 23096±9, quadrant 0.
REQ-023 AVG_LOG2=0, in_valid held high for 40 cycles -> in_ready drops while pend=1 and the engine is busy, every accepted sample yields exactly one out_valid, and there is no duplicate or loss.
REQ-024 rst asserted at ROT iteration 5, then (0,300) -> no stale strobe, then one result with theta 32768±9 and quadrant 0.
REQ-025 AVG_LOG2=2, 2 samples then clr, then 4 samples of (50,50) -> exactly one result, theta 16384±9.
